// File: rtl/vec_elem_seq_pkg.sv
// vec_elem_seq_pkg: shared constants for the vector element sequencer.
// Holds the state encoding, vtype field offsets and the default VLEN.
package vec_elem_seq_pkg;

  localparam int VLEN_DEF = 64;

  localparam int VT_VALID   = 6;
  localparam int VT_SEW_HI  = 5;
  localparam int VT_SEW_LO  = 3;
  localparam int VT_LMUL_HI = 2;
  localparam int VT_LMUL_LO = 0;

  localparam logic [2:0] MAX_SEW  = 3'd3;
  localparam logic [2:0] MAX_LMUL = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // n low bytes set, n in 0..8
  function automatic logic [7:0] low_bytes(input logic [3:0] n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return t[7:0];
  endfunction

endpackage

// File: rtl/vec_byte_mask.sv
// vec_byte_mask: per-beat element index, byte mask and last-beat flag.
// Purely combinational; fed from the sequencer's captured state.
module vec_byte_mask
  import vec_elem_seq_pkg::*;
#(
  parameter int VLEN = VLEN_DEF
) (
  input  logic [1:0] sew_i,
  input  logic [2:0] beat_i,
  input  logic [6:0] vl_i,
  input  logic [6:0] vstart_i,
  output logic [6:0] elem_o,
  output logic [7:0] mask_o,
  output logic       last_o
);

  localparam logic [3:0] BEAT_BYTES = 4'(VLEN / 8);

  logic [3:0] epb;
  logic [6:0] rem;
  logic [6:0] skip;
  logic [3:0] act;
  logic [3:0] nskip;

  always_comb begin
    epb    = BEAT_BYTES >> sew_i;
    elem_o = 7'(beat_i) * 7'(epb);
    rem    = vl_i - elem_o;
    act    = (rem >= 7'(epb)) ? epb : rem[3:0];
    // elements below vstart only ever fall in the first beat
    skip   = (vstart_i > elem_o) ? (vstart_i - elem_o) : 7'd0;
    nskip  = (skip >= 7'(epb)) ? epb : skip[3:0];
    mask_o = low_bytes(4'(act << sew_i))
           & ~low_bytes(4'(nskip << sew_i));
    last_o = ({1'b0, elem_o} + {4'd0, epb})
           >= {1'b0, vl_i};
  end

endmodule

// File: rtl/vec_elem_seq.sv
// vec_elem_seq: walks the registers of an LMUL group, one beat per handshake.
// Define VEC_VSTART_EN to add the vstart port and skip leading elements.
module vec_elem_seq
  import vec_elem_seq_pkg::*;
#(
  parameter int VLEN = VLEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
`ifdef VEC_VSTART_EN
  input  logic [6:0] vstart,
`endif
  input  logic       start,
  input  logic [6:0] vl,
  input  logic [6:0] vtype,
  output logic       busy,
  output logic       beat_valid,
  input  logic       beat_ready,
  output logic [2:0] beat_idx,
  output logic [6:0] elem_idx,
  output logic [7:0] byte_mask,
  output logic       beat_last,
  output logic       done,
  output logic       err
);

  state_e     state_q, state_d;
  logic [1:0] sew_q, sew_d;
  logic [6:0] vl_q, vl_d;
  logic [6:0] vs_q, vs_d;
  logic [2:0] beat_q, beat_d;
  logic       empty_q, empty_d;
  logic       err_q, err_d;

  logic [6:0] vs_in;
  logic [2:0] sew_f;
  logic [2:0] lmul_f;
  logic       legal;
  logic [3:0] epb_in;
  logic [6:0] cap_in;
  logic [6:0] vl_eff;
  logic [2:0] first_in;

  logic [6:0] elem;
  logic [7:0] mask;
  logic       last;

`ifdef VEC_VSTART_EN
  assign vs_in = vstart;
`else
  assign vs_in = '0;
`endif

  assign sew_f  = vtype[VT_SEW_HI:VT_SEW_LO];
  assign lmul_f = vtype[VT_LMUL_HI:VT_LMUL_LO];
  assign legal  = vtype[VT_VALID]
               && (sew_f <= MAX_SEW)
               && (lmul_f <= MAX_LMUL);

  // group capacity clamps vl so beats never exceed 1<<LMUL
  assign epb_in   = 4'(VLEN / 8) >> sew_f[1:0];
  assign cap_in   = 7'(epb_in) << lmul_f[1:0];
  assign vl_eff   = (vl > cap_in) ? cap_in : vl;
  assign first_in = 3'(vs_in >> (2'd3 - sew_f[1:0]));

  vec_byte_mask #(
    .VLEN(VLEN)
  ) u_mask (
    .sew_i   (sew_q),
    .beat_i  (beat_q),
    .vl_i    (vl_q),
    .vstart_i(vs_q),
    .elem_o  (elem),
    .mask_o  (mask),
    .last_o  (last)
  );

  always_comb begin
    state_d = state_q;
    sew_d   = sew_q;
    vl_d    = vl_q;
    vs_d    = vs_q;
    beat_d  = beat_q;
    empty_d = empty_q;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!legal) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            sew_d   = sew_f[1:0];
            vl_d    = vl_eff;
            vs_d    = vs_in;
            beat_d  = first_in;
            empty_d = (vs_in >= vl_eff);
          end
        end
      end
      ST_RUN: begin
        if (empty_q) begin
          state_d = ST_DONE;
        end else if (beat_ready) begin
          if (last) state_d = ST_DONE;
          else      beat_d  = beat_q + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sew_q   <= '0;
      vl_q    <= '0;
      vs_q    <= '0;
      beat_q  <= '0;
      empty_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sew_q   <= sew_d;
      vl_q    <= vl_d;
      vs_q    <= vs_d;
      beat_q  <= beat_d;
      empty_q <= empty_d;
      err_q   <= err_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign beat_valid = (state_q == ST_RUN) && !empty_q;
  assign beat_idx   = beat_valid ? beat_q : '0;
  assign elem_idx   = beat_valid ? elem : '0;
  assign byte_mask  = beat_valid ? mask : '0;
  assign beat_last  = beat_valid && last;
  assign done       = (state_q == ST_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_vec_elem_seq.sv
// tb_vec_elem_seq: directed scenarios plus randomized instructions
// checked against an element-level reference model.
module tb_vec_elem_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       beat_ready = 1'b0;
  logic [6:0] vl = '0;
  logic [6:0] vtype = '0;
`ifdef VEC_VSTART_EN
  logic [6:0] vstart = '0;
`endif
  logic       busy, beat_valid, beat_last, done, err;
  logic [2:0] beat_idx;
  logic [6:0] elem_idx;
  logic [7:0] byte_mask;

  int errors = 0;
  int checks = 0;
  logic [22:0] want;

  always #5 clk = ~clk;

  vec_elem_seq #(.VLEN(64)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef VEC_VSTART_EN
    .vstart    (vstart),
`endif
    .start     (start),
    .vl        (vl),
    .vtype     (vtype),
    .busy      (busy),
    .beat_valid(beat_valid),
    .beat_ready(beat_ready),
    .beat_idx  (beat_idx),
    .elem_idx  (elem_idx),
    .byte_mask (byte_mask),
    .beat_last (beat_last),
    .done      (done),
    .err       (err)
  );

  // {busy,valid,beat_idx,elem_idx,mask,last,done,err}
  wire [22:0] obs = {busy, beat_valid, beat_idx, elem_idx,
                     byte_mask, beat_last, done, err};

  function automatic logic [22:0] pk(
    bit b, bit v, int bi, int ei, int m, bit l, bit d, bit e);
    return {b, v, 3'(bi), 7'(ei), 8'(m), l, d, e};
  endfunction

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; vl = 7'd5;
    vtype = 7'h40; beat_ready = 1'b1;
    repeat (3) @(negedge clk);
    want = '0; checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs, want);
    end
    rst = 1'b0; start = 1'b0; beat_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", obs, want);
    end
  endtask

  task automatic test_single_beat();
    vl = 7'd5; vtype = 7'h40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    want = pk(1, 1, 0, 0, 'h1F, 1, 0, 0); checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL single_beat: got %h want %h", obs, want);
    end
    beat_ready = 1'b1;
    @(negedge clk);
    beat_ready = 1'b0;
    want = pk(1, 0, 0, 0, 0, 0, 1, 0); checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL single_done: got %h want %h", obs, want);
    end
    @(negedge clk);
    want = '0; checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL single_idle: got %h want %h", obs, want);
    end
  endtask

  task automatic test_multi_beat();
    int me[3] = '{0, 2, 4};
    int mm[3] = '{'hFF, 'hFF, 'h0F};
    vl = 7'd5; vtype = 7'h52; start = 1'b1; beat_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 3; b++) begin
      want = pk(1, 1, b, me[b], mm[b], b == 2, 0, 0); checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL multi_beat%0d: got %h want %h", b, obs, want);
      end
      @(negedge clk);
    end
    beat_ready = 1'b0;
    want = pk(1, 0, 0, 0, 0, 0, 1, 0); checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL multi_done: got %h want %h", obs, want);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    vl = 7'd5; vtype = 7'h52; start = 1'b1; beat_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    want = pk(1, 1, 0, 0, 'hFF, 0, 0, 0); checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL stall_b0: got %h want %h", obs, want);
    end
    beat_ready = 1'b1;
    @(negedge clk);
    // junk start while running must be ignored
    beat_ready = 1'b0; start = 1'b1; vl = 7'd1; vtype = 7'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      want = pk(1, 1, 1, 2, 'hFF, 0, 0, 0); checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL stall_hold%0d: got %h want %h", i, obs, want);
      end
    end
    beat_ready = 1'b1; start = 1'b0;
    @(negedge clk);
    want = pk(1, 1, 2, 4, 'h0F, 1, 0, 0); checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL stall_b2: got %h want %h", obs, want);
    end
    @(negedge clk);
    beat_ready = 1'b0;
    want = pk(1, 0, 0, 0, 0, 0, 1, 0); checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL stall_done: got %h want %h", obs, want);
    end
    @(negedge clk);
  endtask

  task automatic test_vl_zero_err();
    logic [6:0] bad[3] = '{7'h00, 7'h60, 7'h44};
    vl = 7'd0; vtype = 7'h40; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    want = pk(1, 0, 0, 0, 0, 0, 0, 0); checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL zero_run: got %h want %h", obs, want);
    end
    @(negedge clk);
    want = pk(1, 0, 0, 0, 0, 0, 1, 0); checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL zero_done: got %h want %h", obs, want);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vl = 7'd5; vtype = bad[i]; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      want = pk(0, 0, 0, 0, 0, 0, 0, 1); checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL err_pulse%0d: got %h want %h", i, obs, want);
      end
      @(negedge clk);
      want = '0; checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL err_clear%0d: got %h want %h", i, obs, want);
      end
    end
  endtask

  task automatic test_rst_mid_run();
    vl = 7'd32; vtype = 7'h42; start = 1'b1; beat_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      want = pk(1, 1, b, b * 8, 'hFF, 0, 0, 0); checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL rst_pre%0d: got %h want %h", b, obs, want);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; beat_ready = 1'b0;
    want = '0; checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL rst_mid: got %h want %h", obs, want);
    end
    @(negedge clk);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL rst_no_done: got %h want %h", obs, want);
    end
  endtask

`ifdef VEC_VSTART_EN
  task automatic test_vstart();
    vl = 7'd6; vtype = 7'h49; vstart = 7'd3;
    start = 1'b1; beat_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    want = pk(1, 1, 0, 0, 'hC0, 0, 0, 0); checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL vstart_b0: got %h want %h", obs, want);
    end
    @(negedge clk);
    want = pk(1, 1, 1, 4, 'h0F, 1, 0, 0); checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL vstart_b1: got %h want %h", obs, want);
    end
    @(negedge clk);
    beat_ready = 1'b0; vstart = '0;
    want = pk(1, 0, 0, 0, 0, 0, 1, 0); checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL vstart_done: got %h want %h", obs, want);
    end
    @(negedge clk);
  endtask
`endif

  task automatic test_random();
    int v, s, l, vs, epb, cap, ev, first, lastb, b, cyc;
    bit ok, r;
    bit [7:0] m[8];
    for (int n = 0; n < 80; n++) begin
      v = ($urandom % 3 == 0) ? $urandom % 128 : $urandom % 20;
      s = ($urandom % 8 == 0) ? $urandom % 8 : $urandom % 4;
      l = ($urandom % 8 == 0) ? $urandom % 8 : $urandom % 4;
      ok = ($urandom % 10 != 0);
      vs = 0;
`ifdef VEC_VSTART_EN
      vs = $urandom % (v + 2);
      vstart = 7'(vs);
`endif
      vl = 7'(v); vtype = {ok, 3'(s), 3'(l)};
      start = 1'b1; beat_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      if (!ok || s > 3 || l > 3) begin
        want = pk(0, 0, 0, 0, 0, 0, 0, 1); checks++;
        if (obs !== want) begin
          errors++;
          $display("FAIL rnd_err: got %h want %h", obs, want);
        end
        @(negedge clk);
        continue;
      end
      // reference: place each active element into its beat
      epb = 8 >> s;
      cap = (1 << l) * epb;
      ev = (v < cap) ? v : cap;
      foreach (m[i]) m[i] = '0;
      for (int e = vs; e < ev; e++)
        m[e / epb] |= 8'(((1 << (1 << s)) - 1) << ((e % epb) * (1 << s)));
      if (vs >= ev) begin
        want = pk(1, 0, 0, 0, 0, 0, 0, 0); checks++;
        if (obs !== want) begin
          errors++;
          $display("FAIL rnd_empty: got %h want %h", obs, want);
        end
        @(negedge clk);
      end else begin
        first = vs / epb;
        lastb = (ev - 1) / epb;
        b = first;
        cyc = 0;
        while (b <= lastb && cyc < 100) begin
          want = pk(1, 1, b, b * epb, m[b], b == lastb, 0, 0);
          checks++;
          if (obs !== want) begin
            errors++;
            $display("FAIL rnd_beat%0d: got %h want %h", b, obs, want);
          end
          r = ($urandom % 4 != 0);
          beat_ready = r;
          start = 1'($urandom % 2);
          vl = 7'($urandom); vtype = 7'($urandom);
          @(negedge clk);
          if (r) b++;
          cyc++;
        end
        if (cyc >= 100) begin
          errors++;
          $display("FAIL rnd_timeout: got beat %0d want %0d", b, lastb);
        end
      end
      start = 1'b0; beat_ready = 1'b0;
      want = pk(1, 0, 0, 0, 0, 0, 1, 0); checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL rnd_done: got %h want %h", obs, want);
      end
      @(negedge clk);
      want = '0; checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL rnd_idle: got %h want %h", obs, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_multi_beat();
    test_stall();
    test_vl_zero_err();
    test_rst_mid_run();
`ifdef VEC_VSTART_EN
    test_vstart();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
